// File: rtl/divider.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient (LO) and remainder (HI) valid with a one-cycle div_done pulse.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   div_start             request, accepted only while idle
//   div_signed            1 = two's complement (DIV), 0 = unsigned (DIVU)
//   dividend, divisor     operands, sampled with div_start
//   div_busy              high whenever an operation is in progress
//   div_done              one-cycle pulse when results are updated
//   quotient, remainder   results, held until the next operation completes
module divider #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  div_start,
    input  logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  div_busy,
    output logic                  div_done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic          sgn_q, sgn_d;
    logic          dvd_neg_q, dvd_neg_d;
    logic          dvs_neg_q, dvs_neg_d;
    logic          dz_q, dz_d;
    logic [DW:0]   rem_q, rem_d;      // partial remainder, one spare bit
    logic [DW-1:0] acc_q, acc_d;      // dividend shifts out, quotient shifts in
    logic [DW-1:0] dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_d, rmd_d;
    logic          busy_d, done_d;

    logic [DW:0]   shifted;
    logic [DW+1:0] trial;

    // Trial subtraction; the extra top bit of trial is the borrow/sign
    assign shifted = {rem_q[DW-1:0], acc_q[DW-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            rem_q     <= '0;
            acc_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_busy  <= 1'b0;
            div_done  <= 1'b0;
        end else begin
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dz_q      <= dz_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            quotient  <= quo_d;
            remainder <= rmd_d;
            div_busy  <= busy_d;
            div_done  <= done_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dz_d      = dz_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        quo_d     = quotient;
        rmd_d     = remainder;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_start) begin
                    // Magnitudes are taken as unsigned, so 0x80000000 maps to 2^31
                    sgn_d     = div_signed;
                    dvd_neg_d = div_signed & dividend[DW-1];
                    dvs_neg_d = div_signed & divisor[DW-1];
                    dz_d      = (divisor == '0);
                    acc_d     = (div_signed & dividend[DW-1]) ? DW'(-dividend) : dividend;
                    dvs_d     = (div_signed & divisor[DW-1])  ? DW'(-divisor)  : divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (!trial[DW+1]) begin
                    rem_d = trial[DW:0];
                    acc_d = {acc_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    acc_d = {acc_q[DW-2:0], 1'b0};
                end
                if (cnt_q == CW'(DW - 1)) state_d = FIX;
                else                      cnt_d   = cnt_q + CW'(1);
            end
            FIX: begin
                // Divide by zero leaves |dividend| in rem; sign fix restores the original
                quo_d   = (sgn_q & (dvd_neg_q ^ dvs_neg_q)) ? DW'(-acc_q) : acc_q;
                rmd_d   = (sgn_q & dvd_neg_q) ? DW'(-rem_q[DW-1:0]) : rem_q[DW-1:0];
                if (dz_q) quo_d = '1;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases, a random batch against a
// behavioural model, ignored start while busy, and reset abort.
module tb_divider;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_busy;
    logic        div_done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_seen = 0;

    divider #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_busy   (div_busy),
        .div_done   (div_done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa, sb_;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            sa  = int'(a);
            sb_ = int'(b);
            e.q = 32'(sa / sb_);
            e.r = 32'(sa % sb_);
        end
        return e;
    endfunction

    // Scoreboard: compare each completed operation against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && div_done) begin
            done_seen++;
            check_eq("sb_pending", 32'(sb.size() != 0), 32'd1);
            check_eq("busy_in_done", 32'(div_busy), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("quotient", quotient, e.q);
                check_eq("remainder", remainder, e.r);
            end
        end
    end

    // Issue one operation (called at a negedge with the DUT idle) and track it to completion
    task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input exp_t e, input int inject);
        logic [31:0] prev_q;
        int          cycles;
        logic        got;
        prev_q     = quotient;
        div_signed = s;
        dividend   = a;
        divisor    = b;
        div_start  = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 div_start = 1'b0;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) check_eq("busy_after_accept", 32'(div_busy), 32'd1);
            if (cycles == 5) check_eq("hold_prev_q", quotient, prev_q);
            if (inject != 0 && cycles == inject) begin
                div_signed = 1'b0;
                dividend   = 32'd5;
                divisor    = 32'd1;
                div_start  = 1'b1;
            end
            if (inject != 0 && cycles == inject + 1) div_start = 1'b0;
            if (div_done) got = 1'b1;
        end
        check_eq("latency", 32'(cycles), 32'd34);
        @(negedge clk);
        check_eq("busy_after_done", 32'(div_busy), 32'd0);
        check_eq("done_pulse_width", 32'(div_done), 32'd0);
        check_eq("hold_q", quotient, e.q);
        check_eq("hold_r", remainder, e.r);
    endtask

    initial begin
        exp_t        e;
        logic        s;
        logic [31:0] a, b;
        int          d0;

        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(div_busy), 32'd0);
        check_eq("rst_done", 32'(div_done), 32'd0);
        check_eq("rst_q", quotient, 32'd0);
        check_eq("rst_r", remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        e = '{q: 32'h0000_000E, r: 32'h0000_0002}; run_op(1'b0, 32'd100, 32'd7, e, 0);
        e = '{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF}; run_op(1'b1, 32'hFFFF_FFF9, 32'd2, e, 0);
        e = '{q: 32'hFFFF_FFFD, r: 32'h0000_0001}; run_op(1'b1, 32'd7, 32'hFFFF_FFFE, e, 0);
        e = '{q: 32'h7FFF_FFFC, r: 32'h0000_0001}; run_op(1'b0, 32'hFFFF_FFF9, 32'd2, e, 0);
        e = '{q: 32'hFFFF_FFFF, r: 32'hFFFF_FF85}; run_op(1'b1, 32'hFFFF_FF85, 32'd0, e, 0);
        e = '{q: 32'hFFFF_FFFF, r: 32'h1234_5678}; run_op(1'b0, 32'h1234_5678, 32'd0, e, 0);
        e = '{q: 32'h8000_0000, r: 32'h0000_0000}; run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, 0);
        e = '{q: 32'h0000_0001, r: 32'h0000_0000}; run_op(1'b1, 32'h8000_0000, 32'h8000_0000, e, 0);
        e = '{q: 32'h0000_0064, r: 32'h0000_0000}; run_op(1'b0, 32'd1000, 32'd10, e, 10);

        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (i % 4 == 1) b = -b;
            run_op(s, a, b, model(s, a, b), 0);
        end

        // Reset in the middle of an operation
        d0         = done_seen;
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd10;
        div_start  = 1'b1;
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy", 32'(div_busy), 32'd0);
        check_eq("abort_q", quotient, 32'd0);
        check_eq("abort_r", remainder, 32'd0);
        rst = 1'b0;
        e = '{q: 32'h0000_000E, r: 32'h0000_0002}; run_op(1'b0, 32'd100, 32'd7, e, 0);
        repeat (40) @(negedge clk);
        check_eq("done_count_after_abort", 32'(done_seen - d0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
